if_fetch_unit: RTL and testbench

//  IF-stage producer feeding if_id_seg (if_pc/if_inst/if_ex), driving the instruction SRAM-like bus (req/addr_ok/data_ok).

---
 rtl/if_fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage producer. Drives an SRAM-like instruction bus
//   (req / addr_ok / data_ok) and presents one instruction at a time to the
//   IF/ID segment register. Exactly one instruction is in progress at any
//   moment (requested, in flight, or held), so the instruction that is in
//   progress when ID reports a taken branch is by construction its delay slot.
//
//   Optional feature macro: IF_ADEL_CHECK_EN
//     When defined, a misaligned fetch PC suppresses the bus request and
//     presents a nop tagged with the address-error bit instead.
//
// Ports
//   clk, reset              clock (posedge), asynchronous active-high reset
//   stall                   IF/ID not accepting this cycle
//   refresh, flush_pc       pipeline flush and restart target
//   redirect, redirect_pc   taken branch/jump from ID (1-cycle pulse)
//   inst_req, inst_addr     bus request / word-aligned address
//   inst_addr_ok            request accepted
//   inst_data_ok, inst_rdata read data return
//   if_valid, if_pc,
//   if_inst, if_ex          instruction presented to IF/ID
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          NUM_EX   = 16,
  parameter int          ADEL_BIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              refresh,
  input  logic [31:0]       flush_pc,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              inst_req,
  output logic [31:0]       inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [31:0]       inst_rdata,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_inst,
  output logic [NUM_EX-1:0] if_ex
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;

  logic        adel;
  logic        adel_present;
  logic        deliver;

`ifdef IF_ADEL_CHECK_EN
  assign adel = (fetch_pc_q[1:0] != 2'b00);
`else
  assign adel = 1'b0;
`endif

  // ---- output decode (bus data passes straight through, no added latency)
  always_comb begin
    inst_req     = 1'b0;
    if_valid     = 1'b0;
    if_inst      = 32'h0;
    adel_present = 1'b0;
    if (!reset) begin
      inst_req = (state_q == S_REQ) && !adel;
      if (!refresh) begin
        unique case (state_q)
          S_REQ: begin
            // A misaligned PC is reported as a nop carrying the error flag.
            if_valid     = adel;
            adel_present = adel;
          end
          S_RESP: begin
            if_valid = inst_data_ok;
            if_inst  = inst_data_ok ? inst_rdata : 32'h0;
          end
          S_HOLD: begin
            if_valid = 1'b1;
            if_inst  = hold_inst_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign inst_addr = {fetch_pc_q[31:2], 2'b00};
  assign if_pc     = fetch_pc_q;
  assign if_ex     = NUM_EX'(adel_present) << ADEL_BIT;
  assign deliver   = if_valid && !stall;

  // ---- next-state
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    hold_inst_d  = hold_inst_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
    if (refresh) begin
      // Flush beats stall and redirect. Anything already accepted by the bus
      // must be drained through DROP so its data is not mistaken for the
      // restart target's instruction.
      fetch_pc_d   = flush_pc;
      redir_pend_d = 1'b0;
      unique case (state_q)
        S_REQ:   state_d = (inst_req && inst_addr_ok) ? S_DROP : S_REQ;
        S_RESP:  state_d = inst_data_ok ? S_REQ : S_DROP;
        S_HOLD:  state_d = S_REQ;
        S_DROP:  state_d = inst_data_ok ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (!adel && inst_addr_ok) state_d = S_RESP;
        end
        S_RESP: begin
          if (inst_data_ok) begin
            if (stall) begin
              hold_inst_d = inst_rdata;
              state_d     = S_HOLD;
            end else begin
              state_d = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!stall) state_d = S_REQ;
        end
        S_DROP: begin
          if (inst_data_ok) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase

      if (deliver) begin
        // Same-cycle redirect wins over an older pending target.
        fetch_pc_d   = redirect     ? redirect_pc :
                       redir_pend_q ? redir_tgt_q : fetch_pc_q + 32'd4;
        redir_pend_d = 1'b0;
      end else if (redirect) begin
        // The in-progress instruction is the delay slot; remember the target.
        redir_pend_d = 1'b1;
        redir_tgt_d  = redirect_pc;
      end
    end
  end

  // ---- state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC;
      hold_inst_q  <= 32'h0;
      redir_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      hold_inst_q  <= hold_inst_d;
      redir_pend_q <= redir_pend_d;
    end
  end

  // Target is only meaningful while redir_pend_q is set.
  always_ff @(posedge clk) begin
    redir_tgt_q <= redir_tgt_d;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam int NUM_EX   = 16;
  localparam int ADEL_BIT = 0;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall, refresh, redirect;
  logic [31:0]       flush_pc, redirect_pc;
  logic              inst_req;
  logic [31:0]       inst_addr;
  logic              inst_addr_ok, inst_data_ok;
  logic [31:0]       inst_rdata;
  logic              if_valid;
  logic [31:0]       if_pc, if_inst;
  logic [NUM_EX-1:0] if_ex;

  int errors = 0;
  int checks = 0;

  if_fetch_unit #(
    .RESET_PC(32'hBFC0_0000),
    .NUM_EX  (NUM_EX),
    .ADEL_BIT(ADEL_BIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .refresh     (refresh),
    .flush_pc    (flush_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .if_ex       (if_ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, then clear all inputs.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    stall = 0; refresh = 0; redirect = 0;
    inst_addr_ok = 0; inst_data_ok = 0;
  endtask

  // Let combinational outputs settle after inputs were set.
  task automatic settle();
    #2;
  endtask

  initial begin
    reset = 1; stall = 0; refresh = 0; redirect = 0;
    flush_pc = 0; redirect_pc = 0;
    inst_addr_ok = 1; inst_data_ok = 1; inst_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1; settle();
    chk("rst_req",   {31'd0, inst_req}, 0);
    chk("rst_valid", {31'd0, if_valid}, 0);
    chk("rst_inst",  if_inst, 32'h0);
    chk("rst_ex",    32'(if_ex), 0);
    @(posedge clk); #1;
    reset = 0; inst_addr_ok = 0; inst_data_ok = 0;

    // Plain fetch: REQ/RESP pairs
    inst_addr_ok = 1; settle();
    chk("f0_req",   {31'd0, inst_req}, 1);
    chk("f0_addr",  inst_addr, 32'hBFC0_0000);
    chk("f0_valid", {31'd0, if_valid}, 0);
    next_cycle();
    inst_data_ok = 1; inst_rdata = 32'h1111_1111; settle();
    chk("f0_dvalid", {31'd0, if_valid}, 1);
    chk("f0_inst",   if_inst, 32'h1111_1111);
    chk("f0_pc",     if_pc, 32'hBFC0_0000);
    chk("f0_noreq",  {31'd0, inst_req}, 0);
    chk("f0_ex",     32'(if_ex), 0);
    next_cycle();
    inst_addr_ok = 1; settle();
    chk("f1_addr",  inst_addr, 32'hBFC0_0004);
    chk("f1_valid", {31'd0, if_valid}, 0);
    chk("f1_inst",  if_inst, 32'h0);

    // Stall for 3 cycles while data returns -> HOLD
    next_cycle();
    inst_data_ok = 1; inst_rdata = 32'h2222_2222; stall = 1; settle();
    chk("h0_valid", {31'd0, if_valid}, 1);
    chk("h0_inst",  if_inst, 32'h2222_2222);
    next_cycle();
    inst_rdata = 32'hDEAD_BEEF; stall = 1; settle();
    chk("h1_valid", {31'd0, if_valid}, 1);
    chk("h1_inst",  if_inst, 32'h2222_2222);
    chk("h1_noreq", {31'd0, inst_req}, 0);
    next_cycle();
    stall = 1; settle();
    chk("h2_inst",  if_inst, 32'h2222_2222);
    next_cycle();
    settle();
    chk("h3_valid", {31'd0, if_valid}, 1);
    chk("h3_inst",  if_inst, 32'h2222_2222);
    chk("h3_pc",    if_pc, 32'hBFC0_0004);
    next_cycle();
    inst_addr_ok = 1; settle();
    chk("h4_req",  {31'd0, inst_req}, 1);
    chk("h4_addr", inst_addr, 32'hBFC0_0008);

    // Redirect while RESP on BFC00008: it is the delay slot
    next_cycle();
    redirect = 1; redirect_pc = 32'h8000_0100; settle();
    chk("r0_valid", {31'd0, if_valid}, 0);
    next_cycle();
    inst_data_ok = 1; inst_rdata = 32'h3333_3333; settle();
    chk("r1_valid", {31'd0, if_valid}, 1);
    chk("r1_inst",  if_inst, 32'h3333_3333);
    chk("r1_pc",    if_pc, 32'hBFC0_0008);
    next_cycle();
    inst_addr_ok = 1; settle();
    chk("r2_addr", inst_addr, 32'h8000_0100);

    // Refresh in RESP before data_ok: stale data dropped
    next_cycle();
    refresh = 1; flush_pc = 32'hBFC0_0380; settle();
    chk("d0_valid", {31'd0, if_valid}, 0);
    next_cycle();
    inst_data_ok = 1; inst_rdata = 32'h4444_4444; settle();
    chk("d1_valid", {31'd0, if_valid}, 0);
    chk("d1_inst",  if_inst, 32'h0);
    chk("d1_noreq", {31'd0, inst_req}, 0);
    next_cycle();
    settle();
    chk("d2_req",  {31'd0, inst_req}, 1);
    chk("d2_addr", inst_addr, 32'hBFC0_0380);
    next_cycle();
    inst_addr_ok = 1; settle();
    chk("d3_addr", inst_addr, 32'hBFC0_0380);

    // Refresh with a pending redirect: pending target discarded
    next_cycle();
    redirect = 1; redirect_pc = 32'h8000_0200; settle();
    next_cycle();
    refresh = 1; flush_pc = 32'hBFC0_0400; settle();
    chk("p0_valid", {31'd0, if_valid}, 0);
    next_cycle();
    inst_data_ok = 1; settle();
    chk("p1_valid", {31'd0, if_valid}, 0);
    next_cycle();
    inst_addr_ok = 1; settle();
    chk("p2_addr", inst_addr, 32'hBFC0_0400);
    next_cycle();
    inst_data_ok = 1; inst_rdata = 32'h5555_5555; settle();
    chk("p3_valid", {31'd0, if_valid}, 1);
    chk("p3_pc",    if_pc, 32'hBFC0_0400);
    next_cycle();
    settle();
    chk("p4_addr", inst_addr, 32'hBFC0_0404);

    // Refresh + stall together on data return: refresh wins
    inst_addr_ok = 1; settle();
    next_cycle();
    inst_data_ok = 1; stall = 1; refresh = 1; flush_pc = 32'hBFC0_0500; settle();
    chk("s0_valid", {31'd0, if_valid}, 0);
    next_cycle();
    settle();
    chk("s1_req",  {31'd0, inst_req}, 1);
    chk("s1_addr", inst_addr, 32'hBFC0_0500);

`ifdef IF_ADEL_CHECK_EN
    // Redirect to a misaligned target: address-error nop
    inst_addr_ok = 1; settle();
    next_cycle();
    inst_data_ok = 1; inst_rdata = 32'h6666_6666;
    redirect = 1; redirect_pc = 32'h8000_0002; settle();
    chk("a0_valid", {31'd0, if_valid}, 1);
    next_cycle();
    settle();
    chk("a1_noreq", {31'd0, inst_req}, 0);
    chk("a1_valid", {31'd0, if_valid}, 1);
    chk("a1_inst",  if_inst, 32'h0);
    chk("a1_ex",    32'(if_ex), 32'(1) << ADEL_BIT);
    chk("a1_pc",    if_pc, 32'h8000_0002);
    next_cycle();
    refresh = 1; flush_pc = 32'h8000_1000; settle();
    chk("a2_valid", {31'd0, if_valid}, 0);
    next_cycle();
    settle();
    chk("a3_req",  {31'd0, inst_req}, 1);
    chk("a3_addr", inst_addr, 32'h8000_1000);
`else
    // Without the check, low PC bits never suppress the request
    inst_addr_ok = 1; settle();
    next_cycle();
    inst_data_ok = 1; inst_rdata = 32'h6666_6666;
    redirect = 1; redirect_pc = 32'h8000_0002; settle();
    chk("a0_valid", {31'd0, if_valid}, 1);
    next_cycle();
    settle();
    chk("a1_req",  {31'd0, inst_req}, 1);
    chk("a1_addr", inst_addr, 32'h8000_0000);
    chk("a1_valid", {31'd0, if_valid}, 0);
    inst_addr_ok = 1;
    next_cycle();
    inst_data_ok = 1; inst_rdata = 32'h7777_7777; settle();
    chk("a2_inst", if_inst, 32'h7777_7777);
    chk("a2_ex",   32'(if_ex), 0);
    chk("a2_pc",   if_pc, 32'h8000_0002);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
